ccg_result_drain: RTL and testbench
===================================

# ccg_result_drain

Read-side companion of `cim_cell_group`: captures the full `N_GROUP`-word result vector on a capture strobe and streams it out one word per beat over a valid/ready master interface, group 0 first. It sits between the CiM cell-group array and the result collection path, and it frees the array for the next `w_i`/`b_i` update as soon as the vector is latched.

## Interface
- `N_GROUP`, 12, number of result words per vector (≥2)
- `DATA_WIDTH`, 32, bits per result word
- `IDX_WIDTH`, `$clog2(N_GROUP)`, localparam, beat index width

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `capture_i`  in  1  single-cycle strobe: latch `data_i` this edge
- `data_i`  in  `N_GROUP*DATA_WIDTH`  result vector; word g = bits `[g*DATA_WIDTH +: DATA_WIDTH]`
- `m_valid_o`  out  1  output word valid
- `m_ready_i`  in  1  downstream accepts word
- `m_data_o`  out  `DATA_WIDTH`  current word
- `m_idx_o`  out  `IDX_WIDTH`  group index of current word
- `m_last_o`  out  1  current word is index `N_GROUP-1`
- `busy_o`  out  1  a vector is being drained or is pending
- `drop_o`  out  1  one-cycle pulse: capture rejected

## Operation
- FSM states: IDLE, DRAIN.
- IDLE: `m_valid_o`=0. `capture_i`=1 → latch `data_i` into the active buffer, idx←0, go to DRAIN.
- DRAIN: `m_valid_o`=1, `m_data_o`=active word[idx], `m_last_o`=(idx==N_GROUP-1).
- Handshake = `m_valid_o && m_ready_i`; idx advances by 1 per handshake only. When not ready, data/idx hold stable; valid never drops mid-vector.
- Handshake on last word: if a new vector is available (capture this cycle, or pending shadow buffer), reload it, set idx←0, and stay in DRAIN; otherwise go to IDLE.
- Capture in DRAIN when no buffer space is free: vector discarded, `drop_o` pulses for 1 cycle, and the active drain is unaffected.
- A capture in the same cycle as the last-word handshake is accepted, not dropped.
- `busy_o` = state==DRAIN or a pending vector is held.
- idx never exceeds N_GROUP-1; there is no wrap except the reload to 0.

## Timing
- Reset (async assert, sync release): state IDLE, idx 0, `m_valid_o`=0, `m_data_o`=0, `m_idx_o`=0, `m_last_o`=0, `busy_o`=0, `drop_o`=0, and buffers are cleared.
- All outputs are registered.
- Capture sampled at edge t → first word valid after edge t (one-cycle latency).
- With `m_ready_i` held at 1: N_GROUP beats on consecutive cycles. Back-to-back vectors have no bubble.
- Reset mid-drain: the vector is abandoned and valid drops immediately (asynchronously).

## Configuration
- `CCG_DRAIN_DOUBLE_BUF_EN` defined: adds a shadow buffer plus a pending flag.
  - A capture during DRAIN fills the shadow buffer if it is empty; drop only if it is already full.
  - On the last-word handshake, the shadow moves to the active buffer.
  - If the same cycle also has a capture, the shadow moves to active and the new capture goes to the shadow.
- Undefined: single buffer only. Any capture in DRAIN, other than on the last-word handshake, drops.

## Structure
- `cim_pkg` holds:
  - `ccg_drain_state_e` (IDLE, DRAIN)
  - the index-width helper
  - the default `N_GROUP`/`DATA_WIDTH` constants, shared with `cim_cell_group`
- Sub-module `ccg_drain_buf`: one `N_GROUP*DATA_WIDTH` register with load enable and async clear, plus a word-select read port. It is instantiated once, or twice under the macro.

## Test plan
- N_GROUP=12, word g=32'h1000_0000+g; capture, ready=1 → 12 beats on consecutive cycles, idx 0..11, data 1000_0000..1000_000B, last only on idx 11, then valid=0.
- Same vector, ready toggled 1,0 every cycle → data/idx stable during stalls, 12 handshakes over 23 cycles, no drop.
- Capture during beat 5, macro off → `drop_o` pulses once, and the original vector completes unchanged.
- Capture exactly on the idx 11 handshake with vector 2000_00xx → next cycle valid=1, idx 0, data 2000_0000, no drop.
- Macro on: capture at beat 3 and again at beat 6 → second vector drains right after the first with no bubble. The third capture drops once.
- Assert `rst` low at beat 7 → valid and busy go 0 immediately. A capture after release drains from idx 0.

Source files
------------

// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared CiM types and constants for the cell group and its result drain
package cim_pkg;

  // Default geometry of the cell-group array and its result vector
  localparam int CCG_N_GROUP    = 12;
  localparam int CCG_DATA_WIDTH = 32;

  // Drain sequencer states
  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } ccg_drain_state_e;

  // Width of a word index into an n-word vector (at least one bit)
  function automatic int ccg_idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ccg_drain_buf.sv
// rtl/ccg_drain_buf.sv - one result-vector register with load enable, async clear and word-select read
module ccg_drain_buf
  import cim_pkg::*;
#(
  parameter int N_GROUP    = CCG_N_GROUP,
  parameter int DATA_WIDTH = CCG_DATA_WIDTH,
  parameter int IDX_WIDTH  = ccg_idx_width(CCG_N_GROUP)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_i,
  input  logic [N_GROUP*DATA_WIDTH-1:0] load_data_i,
  input  logic [IDX_WIDTH-1:0]          sel_i,
  output logic [DATA_WIDTH-1:0]         word_o,
  output logic [N_GROUP*DATA_WIDTH-1:0] data_o
);

  logic [N_GROUP*DATA_WIDTH-1:0] vec_q;

  // Whole-vector latch; cleared by reset so no stale result survives it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vec_q <= '0;
    end else if (load_i) begin
      vec_q <= load_data_i;
    end
  end

  assign data_o = vec_q;
  assign word_o = vec_q[sel_i*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/ccg_result_drain.sv
// rtl/ccg_result_drain.sv - latch a CiM result vector and stream it out one word per beat (CCG_DRAIN_DOUBLE_BUF_EN adds a shadow buffer)
module ccg_result_drain
  import cim_pkg::*;
#(
  parameter  int N_GROUP    = CCG_N_GROUP,
  parameter  int DATA_WIDTH = CCG_DATA_WIDTH,
  localparam int IDX_WIDTH  = ccg_idx_width(N_GROUP)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          capture_i,
  input  logic [N_GROUP*DATA_WIDTH-1:0] data_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [DATA_WIDTH-1:0]         m_data_o,
  output logic [IDX_WIDTH-1:0]          m_idx_o,
  output logic                          m_last_o,
  output logic                          busy_o,
  output logic                          drop_o
);

  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(N_GROUP - 1);

  ccg_drain_state_e              state_q;
  logic [IDX_WIDTH-1:0]          idx_q;
  logic                          valid_q;
  logic [DATA_WIDTH-1:0]         data_q;
  logic                          last_q;
  logic                          busy_q;
  logic                          drop_q;

  logic                          hs;
  logic                          last_hs;
  logic [IDX_WIDTH-1:0]          idx_nxt;
  logic                          act_load;
  logic [N_GROUP*DATA_WIDTH-1:0] act_load_data;
  logic [DATA_WIDTH-1:0]         act_word;
  logic [N_GROUP*DATA_WIDTH-1:0] act_data;
  logic [DATA_WIDTH-1:0]         reload_word;
  logic                          drop_now;
  logic                          stay_drain;
  logic                          busy_d;

  assign hs      = valid_q & m_ready_i;
  assign last_hs = hs & last_q;
  assign idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

`ifdef CCG_DRAIN_DOUBLE_BUF_EN
  logic                          pend_q;
  logic                          pend_d;
  logic                          sh_load;
  logic                          act_from_sh;
  logic [DATA_WIDTH-1:0]         sh_word;
  logic [N_GROUP*DATA_WIDTH-1:0] sh_data;

  // Shadow takes a capture mid-drain when empty, or refills as it empties into the active buffer
  assign act_from_sh   = last_hs & pend_q;
  assign act_load      = (state_q == IDLE && capture_i) || (last_hs && (pend_q || capture_i));
  assign sh_load       = capture_i & (((state_q == DRAIN) & ~last_hs & ~pend_q) | (last_hs & pend_q));
  assign drop_now      = capture_i & (state_q == DRAIN) & ~last_hs & pend_q;
  assign act_load_data = act_from_sh ? sh_data : data_i;
  assign reload_word   = act_from_sh ? sh_word : data_i[DATA_WIDTH-1:0];
  assign pend_d        = pend_q ? ~(last_hs & ~capture_i) : sh_load;

  ccg_drain_buf #(
    .N_GROUP    (N_GROUP),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_shadow_buf (
    .clk         (clk),
    .rst         (rst),
    .load_i      (sh_load),
    .load_data_i (data_i),
    .sel_i       ('0),
    .word_o      (sh_word),
    .data_o      (sh_data)
  );

  // Pending flag marks a full shadow buffer waiting for the active drain to finish
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end
`else
  logic act_data_unused;

  // Single buffer: only an idle capture or one landing on the last-word handshake is taken
  assign act_load        = capture_i & ((state_q == IDLE) | last_hs);
  assign drop_now        = capture_i & (state_q == DRAIN) & ~last_hs;
  assign act_load_data   = data_i;
  assign reload_word     = data_i[DATA_WIDTH-1:0];
  assign act_data_unused = ^act_data;
`endif

  ccg_drain_buf #(
    .N_GROUP    (N_GROUP),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_active_buf (
    .clk         (clk),
    .rst         (rst),
    .load_i      (act_load),
    .load_data_i (act_load_data),
    .sel_i       (idx_nxt),
    .word_o      (act_word),
    .data_o      (act_data)
  );

  // Still draining next cycle unless the last word leaves with nothing queued behind it
  assign stay_drain = (state_q == IDLE) ? capture_i : ~(last_hs & ~act_load);
`ifdef CCG_DRAIN_DOUBLE_BUF_EN
  assign busy_d = stay_drain | pend_d;
`else
  assign busy_d = stay_drain;
`endif

  // Drain sequencer with registered stream outputs; word data is prefetched for the next beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= drop_now;
      busy_q <= busy_d;
      case (state_q)
        IDLE: begin
          if (capture_i) begin
            state_q <= DRAIN;
            valid_q <= 1'b1;
            idx_q   <= '0;
            data_q  <= data_i[DATA_WIDTH-1:0];
            last_q  <= 1'b0;
          end
        end
        DRAIN: begin
          if (last_hs) begin
            idx_q  <= '0;
            last_q <= 1'b0;
            if (act_load) begin
              data_q <= reload_word;
            end else begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              data_q  <= '0;
            end
          end else if (hs) begin
            idx_q  <= idx_nxt;
            data_q <= act_word;
            last_q <= (idx_nxt == IDX_LAST);
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;
  assign m_idx_o   = idx_q;
  assign m_last_o  = last_q;
  assign busy_o    = busy_q;
  assign drop_o    = drop_q;

endmodule

// File: tb/tb_ccg_result_drain.sv
// tb/tb_ccg_result_drain.sv - table-driven bench for ccg_result_drain (CCG_DRAIN_DOUBLE_BUF_EN selects the shadow-buffer cases)
module tb_ccg_result_drain;

  localparam int N  = 12;
  localparam int DW = 32;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            capture_i = 1'b0;
  logic [N*DW-1:0] data_i = '0;
  logic            m_valid_o;
  logic            m_ready_i = 1'b0;
  logic [DW-1:0]   m_data_o;
  logic [IW-1:0]   m_idx_o;
  logic            m_last_o;
  logic            busy_o;
  logic            drop_o;

  ccg_result_drain u_dut (
    .clk       (clk),
    .rst       (rst),
    .capture_i (capture_i),
    .data_i    (data_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o),
    .m_idx_o   (m_idx_o),
    .m_last_o  (m_last_o),
    .busy_o    (busy_o),
    .drop_o    (drop_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    int          row;
    bit          cap;
    logic [31:0] base;
    bit          rdy;
    bit          ev;
    int          eidx;
    logic [31:0] edata;
    bit          ebusy;
    bit          edrop;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   row_cnt = 0;

  localparam logic [31:0] VA = 32'h1000_0000;
  localparam logic [31:0] VB = 32'h3000_0000;
  localparam logic [31:0] VC = 32'h2000_0000;
  localparam logic [31:0] VD = 32'h4000_0000;

  task automatic chk(input int tag, input int row, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL t%0d r%0d %s: got %h want %h", tag, row, what, act, exp);
    end
  endtask

  task automatic add(input int tag, input bit cap, input logic [31:0] base, input bit rdy,
                     input bit ev, input int eidx, input logic [31:0] edata,
                     input bit ebusy, input bit edrop);
    vec_t v;
    v.tag = tag; v.row = row_cnt; v.cap = cap; v.base = base; v.rdy = rdy;
    v.ev = ev; v.eidx = eidx; v.edata = edata; v.ebusy = ebusy; v.edrop = edrop;
    tbl.push_back(v);
    row_cnt++;
  endtask

  task automatic drive(input bit cap, input logic [31:0] base, input bit rdy);
    capture_i = cap;
    m_ready_i = rdy;
    for (int g = 0; g < N; g++) data_i[g*DW +: DW] = cap ? base + 32'(g) : 32'h0;
  endtask

  // Apply one row from a negedge, check the registered outputs at the next negedge
  task automatic run_row(input vec_t v);
    drive(v.cap, v.base, v.rdy);
    @(posedge clk);
    @(negedge clk);
    chk(v.tag, v.row, "valid", 32'(m_valid_o), 32'(v.ev));
    chk(v.tag, v.row, "busy", 32'(busy_o), 32'(v.ebusy));
    chk(v.tag, v.row, "drop", 32'(drop_o), 32'(v.edrop));
    if (v.ev) begin
      chk(v.tag, v.row, "idx", 32'(m_idx_o), 32'(v.eidx));
      chk(v.tag, v.row, "data", m_data_o, v.edata);
      chk(v.tag, v.row, "last", 32'(m_last_o), 32'(v.eidx == N - 1));
    end
  endtask

  initial begin
    vec_t h;

    // 1: full-rate drain of one vector
    row_cnt = 0;
    add(1, 1, VA, 1, 1, 0, VA, 1, 0);
    for (int k = 1; k < N; k++) add(1, 0, 0, 1, 1, k, VA + 32'(k), 1, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);

    // 2: ready toggling 1,0 - 12 handshakes over 23 cycles
    row_cnt = 0;
    add(2, 1, VA, 0, 1, 0, VA, 1, 0);
    for (int j = 1; j <= 23; j++) begin
      int ix;
      ix = (j % 2 == 1) ? (j + 1) / 2 : j / 2;
      if (ix >= N) add(2, 0, 0, 1, 0, 0, 0, 0, 0);
      else         add(2, 0, 0, (j % 2 == 1), 1, ix, VA + 32'(ix), 1, 0);
    end
    add(2, 0, 0, 0, 0, 0, 0, 0, 0);

`ifndef CCG_DRAIN_DOUBLE_BUF_EN
    // 3: capture at beat 5 with a single buffer is dropped
    row_cnt = 0;
    add(3, 1, VA, 1, 1, 0, VA, 1, 0);
    for (int k = 1; k < N; k++) add(3, (k == 6), VB, 1, 1, k, VA + 32'(k), 1, (k == 6));
    add(3, 0, 0, 1, 0, 0, 0, 0, 0);
`endif

    // 4: capture coinciding with the last-word handshake reloads without a bubble
    row_cnt = 0;
    add(4, 1, VA, 1, 1, 0, VA, 1, 0);
    for (int k = 1; k < N; k++) add(4, 0, 0, 1, 1, k, VA + 32'(k), 1, 0);
    add(4, 1, VC, 1, 1, 0, VC, 1, 0);
    for (int k = 1; k < N; k++) add(4, 0, 0, 1, 1, k, VC + 32'(k), 1, 0);
    add(4, 0, 0, 1, 0, 0, 0, 0, 0);

`ifdef CCG_DRAIN_DOUBLE_BUF_EN
    // 5: shadow fills at beat 3, third capture at beat 6 drops, shadow drains with no bubble
    row_cnt = 0;
    add(5, 1, VA, 1, 1, 0, VA, 1, 0);
    for (int k = 1; k < N; k++)
      add(5, (k == 3 || k == 6), (k == 3) ? VB : VD, 1, 1, k, VA + 32'(k), 1, (k == 6));
    add(5, 0, 0, 1, 1, 0, VB, 1, 0);
    for (int k = 1; k < N; k++) add(5, 0, 0, 1, 1, k, VB + 32'(k), 1, 0);
    add(5, 0, 0, 1, 0, 0, 0, 0, 0);
`endif

    // Reset state
    #1 rst = 1'b0;
    #3;
    chk(0, 0, "rst valid", 32'(m_valid_o), 32'd0);
    chk(0, 0, "rst idx", 32'(m_idx_o), 32'd0);
    chk(0, 0, "rst data", m_data_o, 32'd0);
    chk(0, 0, "rst last", 32'(m_last_o), 32'd0);
    chk(0, 0, "rst busy", 32'(busy_o), 32'd0);
    chk(0, 0, "rst drop", 32'(drop_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_row(tbl[i]);

    // 6: reset at beat 7 abandons the vector immediately; a fresh capture starts at idx 0
    h.tag = 6; h.base = VA; h.cap = 1; h.rdy = 1; h.ev = 1; h.eidx = 0; h.edata = VA;
    h.ebusy = 1; h.edrop = 0; h.row = 0;
    run_row(h);
    for (int k = 1; k <= 7; k++) begin
      h.cap = 0; h.base = 0; h.eidx = k; h.edata = VA + 32'(k); h.row = k;
      run_row(h);
    end
    #2 rst = 1'b0;
    #1;
    chk(6, 8, "async valid", 32'(m_valid_o), 32'd0);
    chk(6, 8, "async busy", 32'(busy_o), 32'd0);
    chk(6, 8, "async idx", 32'(m_idx_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    h.cap = 0; h.rdy = 0; h.ev = 0; h.ebusy = 0; h.row = 9;
    run_row(h);
    h.cap = 1; h.base = VC; h.rdy = 1; h.ev = 1; h.eidx = 0; h.edata = VC; h.ebusy = 1; h.row = 10;
    run_row(h);
    h.cap = 0; h.base = 0; h.eidx = 1; h.edata = VC + 32'd1; h.row = 11;
    run_row(h);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
